// File: rtl/sbox_share_ctrl.sv
// Shares one combinational AES S-box between the SubBytes (128-bit) and SubWord (32-bit)
// requesters, streaming one byte per cycle and assembling the substituted result in place.
module sbox_share_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         st_req,
   input  logic [127:0] st_data,
   output logic         st_ack,
   output logic         st_done,
   output logic [127:0] st_result,
   input  logic         kw_req,
   input  logic [31:0]  kw_data,
   output logic         kw_ack,
   output logic         kw_done,
   output logic [31:0]  kw_result,
   output logic [7:0]   sb_in,
   input  logic [7:0]   sb_out,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, RUN_ST, RUN_KW, DONE} state_t;

   state_t         state, state_nxt;
   logic [3:0]     cnt;
   logic           last_kw;
   logic           grant_st, grant_kw;
   logic [127:0]   src;

   always_comb begin
      state_nxt = state;
      grant_st  = 1'b0;
      grant_kw  = 1'b0;
      case (state)
         IDLE: begin
            // On a tie the requester not served last wins; last_kw resets high so st wins first.
            if (st_req && (!kw_req || last_kw)) begin
               grant_st  = 1'b1;
               state_nxt = RUN_ST;
            end else if (kw_req) begin
               grant_kw  = 1'b1;
               state_nxt = RUN_KW;
            end
         end
         RUN_ST:  if (cnt == 4'd15) state_nxt = DONE;
         RUN_KW:  if (cnt == 4'd3)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sb_in = 8'h00;
      if (state == RUN_ST || state == RUN_KW)
         sb_in = src[{cnt, 3'b000} +: 8];
   end

   assign st_ack  = grant_st;
   assign kw_ack  = grant_kw;
   assign st_done = (state == DONE) && !last_kw;
   assign kw_done = (state == DONE) && last_kw;
   assign busy    = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         last_kw   <= 1'b1;
         st_result <= 128'd0;
         kw_result <= 32'd0;
      end else begin
         state <= state_nxt;
         if (grant_st || grant_kw) begin
            cnt     <= 4'd0;
            last_kw <= grant_kw;
         end else if (state == RUN_ST || state == RUN_KW) begin
            cnt <= cnt + 4'd1;
         end
         if (state == RUN_ST)
            st_result[{cnt, 3'b000} +: 8] <= sb_out;
         if (state == RUN_KW)
            kw_result[{cnt[1:0], 3'b000} +: 8] <= sb_out;
      end
   end

   // Source operand is pure data and is only observed while RUN_* gates sb_in.
   always_ff @(posedge clk) begin
      if (grant_st)
         src <= st_data;
      else if (grant_kw)
         src <= {96'd0, kw_data};
   end

endmodule
